// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/result handshake bundle for imm_encoder
//
// Purpose: groups the request channel (ValueIn/StartValid/StartReady), the
// abort (Flush) and the result channel (DoneValid/DoneReady plus fields).
// Modports:
//   slave  - the encoder: consumes requests, produces results
//   master - the requester: produces requests, consumes results
interface imm_encoder_if;
  logic [31:0] ValueIn;
  logic        StartValid;
  logic        StartReady;
  logic        Flush;
  logic        DoneValid;
  logic        DoneReady;
  logic        Encodable;
  logic        Inverted;
  logic [3:0]  Rot4;
  logic [7:0]  Imm8;
  logic [11:0] EncodedOut;

  modport slave (
    input  ValueIn, StartValid, Flush, DoneReady,
    output StartReady, DoneValid, Encodable, Inverted, Rot4, Imm8, EncodedOut
  );

  modport master (
    output ValueIn, StartValid, Flush, DoneReady,
    input  StartReady, DoneValid, Encodable, Inverted, Rot4, Imm8, EncodedOut
  );
endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - iterative rotated-immediate encoder for 32-bit constants
//
// Purpose: searches rotate amounts 0..15 (one per cycle) for an 8-bit
// immediate that, rotated right by 2*Rot4, reproduces ValueIn. Optionally
// repeats the search on ~ValueIn so the caller can substitute MVN/BIC.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - imm_encoder_if.slave: request, flush and result channels
// Parameters:
//   TRY_INVERT - 1: search ~ValueIn after a failed direct search
module imm_encoder #(
  parameter bit TRY_INVERT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEARCH     = 2'd1,
    SEARCH_INV = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] value_q;
  logic [3:0]  cnt_q;
  logic        enc_q, inv_q;
  logic [3:0]  rot_q;
  logic [7:0]  imm_q;

  // Candidate test for the current rotation counter. The upper half of a
  // doubled operand shifted left gives a rotate-left without a 32-bit
  // shift-by-32 corner case at r = 0.
  logic [31:0] cand;
  logic [63:0] dbl;
  logic [31:0] rolled;
  logic        searching;
  logic        hit;
  logic        last;

  assign cand      = (state_q == SEARCH_INV) ? ~value_q : value_q;
  assign dbl       = {cand, cand} << {cnt_q, 1'b0};
  assign rolled    = dbl[63:32];
  assign searching = (state_q == SEARCH) || (state_q == SEARCH_INV);
  assign hit       = searching && (rolled[31:8] == 24'd0);
  assign last      = (cnt_q == 4'd15);

  logic accept, load_hit, load_miss, cnt_clr, cnt_inc;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_hit  = 1'b0;
    load_miss = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (bus.Flush) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.StartValid) begin
            accept  = 1'b1;
            cnt_clr = 1'b1;
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            load_hit = 1'b1;
            state_d  = DONE;
          end else if (!last) begin
            cnt_inc = 1'b1;
          end else if (TRY_INVERT) begin
            cnt_clr = 1'b1;
            state_d = SEARCH_INV;
          end else begin
            load_miss = 1'b1;
            state_d   = DONE;
          end
        end
        SEARCH_INV: begin
          if (hit) begin
            load_hit = 1'b1;
            state_d  = DONE;
          end else if (!last) begin
            cnt_inc = 1'b1;
          end else begin
            load_miss = 1'b1;
            state_d   = DONE;
          end
        end
        DONE: begin
          if (bus.DoneReady) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      value_q <= 32'd0;
      cnt_q   <= 4'd0;
      enc_q   <= 1'b0;
      inv_q   <= 1'b0;
      rot_q   <= 4'd0;
      imm_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) value_q <= bus.ValueIn;
      if (cnt_clr)      cnt_q <= 4'd0;
      else if (cnt_inc) cnt_q <= cnt_q + 4'd1;
      // Stale fields are wiped on a new request or abort so a failed
      // encoding always reads back as all-zero.
      if (accept || load_miss || bus.Flush) begin
        enc_q <= 1'b0;
        inv_q <= 1'b0;
        rot_q <= 4'd0;
        imm_q <= 8'd0;
      end else if (load_hit) begin
        enc_q <= 1'b1;
        inv_q <= (state_q == SEARCH_INV);
        rot_q <= cnt_q;
        imm_q <= rolled[7:0];
      end
    end
  end

  assign bus.StartReady = (state_q == IDLE);
  assign bus.DoneValid  = (state_q == DONE);
  assign bus.Encodable  = enc_q;
  assign bus.Inverted   = inv_q;
  assign bus.Rot4       = rot_q;
  assign bus.Imm8       = imm_q;
  assign bus.EncodedOut = {rot_q, imm_q};

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder (both TRY_INVERT settings)
module tb_imm_encoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imm_encoder_if i1 ();
  imm_encoder_if i0 ();

  imm_encoder #(.TRY_INVERT(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));
  imm_encoder #(.TRY_INVERT(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(i0.slave));

  // sel = 1 steers stimulus to / observation from dut1, else dut0
  logic        sel = 1'b1;
  logic [31:0] vin = 32'd0;
  logic        sv = 1'b0;
  logic        dr = 1'b0;
  logic        flush = 1'b0;

  assign i1.ValueIn    = vin;
  assign i0.ValueIn    = vin;
  assign i1.StartValid = sel & sv;
  assign i0.StartValid = ~sel & sv;
  assign i1.DoneReady  = sel & dr;
  assign i0.DoneReady  = ~sel & dr;
  assign i1.Flush      = flush;
  assign i0.Flush      = flush;

  logic        c_sr, c_dv, c_enc, c_inv;
  logic [3:0]  c_rot;
  logic [7:0]  c_imm;
  logic [11:0] c_eo;
  assign c_sr  = sel ? i1.StartReady : i0.StartReady;
  assign c_dv  = sel ? i1.DoneValid  : i0.DoneValid;
  assign c_enc = sel ? i1.Encodable  : i0.Encodable;
  assign c_inv = sel ? i1.Inverted   : i0.Inverted;
  assign c_rot = sel ? i1.Rot4       : i0.Rot4;
  assign c_imm = sel ? i1.Imm8       : i0.Imm8;
  assign c_eo  = sel ? i1.EncodedOut : i0.EncodedOut;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, want);
    end
  endtask

  typedef struct {
    logic [31:0] val;
    logic        enc;
    logic        inv;
    logic [3:0]  rot;
    logic [7:0]  imm;
    int          lat;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] rol32(input logic [31:0] w, input int s);
    if (s == 0) return w;
    return (w << s) | (w >> (32 - s));
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] w, input int s);
    if (s == 0) return w;
    return (w >> s) | (w << (32 - s));
  endfunction

  // Reference minimal-r search, direct pass first, then inverse if enabled.
  function automatic exp_t ref_enc(input logic [31:0] v, input bit ti);
    exp_t e;
    logic found;
    logic [31:0] w, t;
    e.val = v; e.enc = 1'b0; e.inv = 1'b0; e.rot = 4'd0; e.imm = 8'd0;
    e.lat = ti ? 32 : 16;
    found = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 16; r++) begin
        if (!found && (p == 0 || ti)) begin
          w = (p == 1) ? ~v : v;
          t = rol32(w, 2 * r);
          if (t[31:8] == 24'd0) begin
            found = 1'b1;
            e.enc = 1'b1;
            e.inv = (p == 1);
            e.rot = 4'(r);
            e.imm = t[7:0];
            e.lat = 16 * p + r + 1;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic run(input bit s, input logic [31:0] v, input int hold);
    exp_t e;
    int lat;
    logic [13:0] snap;
    @(negedge clk);
    sel = s; vin = v; sv = 1'b1;
    chk("start_ready", 32'(c_sr), 32'd1);
    sb.push_back(ref_enc(v, s));
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0;
    vin = $urandom;
    lat = 0;
    while (!c_dv && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("encodable", 32'(c_enc), 32'(e.enc));
    chk("inverted", 32'(c_inv), 32'(e.inv));
    chk("rot4", 32'(c_rot), 32'(e.rot));
    chk("imm8", 32'(c_imm), 32'(e.imm));
    chk("encoded_out", 32'(c_eo), 32'({e.rot, e.imm}));
    chk("ready_in_done", 32'(c_sr), 32'd0);
    if (c_enc) chk("ror_rebuild", ror32({24'd0, c_imm}, 2 * int'(c_rot)) ^ {32{c_inv}}, e.val);
    snap = {c_enc, c_inv, c_eo};
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_fields", 32'({c_enc, c_inv, c_eo}), 32'(snap));
      chk("hold_valid", 32'({c_dv, c_sr}), 32'b10);
    end
    dr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dr = 1'b0;
    chk("idle_after", 32'({c_dv, c_sr}), 32'b01);
  endtask

  task automatic start_only(input logic [31:0] v);
    @(negedge clk);
    sel = 1'b1; vin = v; sv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0;
    vin = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  im;
    int          kind;
    // reset state
    repeat (2) @(negedge clk);
    sel = 1'b1;
    #1;
    chk("rst_dut1", 32'({c_sr, c_dv, c_enc, c_inv, c_eo}), 32'h8000);
    sel = 1'b0;
    #1;
    chk("rst_dut0", 32'({c_sr, c_dv, c_enc, c_inv, c_eo}), 32'h8000);
    @(negedge clk);
    reset = 1'b1;

    // directed cases
    run(1'b1, 32'h00000000, 0);
    run(1'b1, 32'hFF000000, 0);
    run(1'b1, 32'h000003FC, 0);
    run(1'b1, 32'hFFFFFF00, 0);
    run(1'b0, 32'hFFFFFF00, 0);
    run(1'b1, 32'h00000101, 5);
    run(1'b0, 32'h00000101, 2);
    run(1'b0, 32'hFF000000, 0);

    // flush mid-search
    start_only(32'h00000101);
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", 32'({c_dv, c_sr}), 32'b01);
    run(1'b1, 32'h000000AB, 0);

    // flush beats a simultaneous request in IDLE
    @(negedge clk);
    sel = 1'b1; vin = 32'h5; sv = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0; flush = 1'b0;
    chk("flush_priority", 32'({c_dv, c_sr}), 32'b01);

    // reset mid-search
    start_only(32'h00000101);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid", 32'({c_sr, c_dv, c_enc, c_inv, c_eo}), 32'h8000);
    @(negedge clk);
    reset = 1'b1;
    run(1'b1, 32'h000000AB, 0);

    // random scoreboard
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      im = 8'($urandom);
      case (kind)
        0:       v = $urandom;
        1:       v = ror32({24'd0, im}, 2 * $urandom_range(0, 15));
        2:       v = ~ror32({24'd0, im}, 2 * $urandom_range(0, 15));
        default: v = $urandom & $urandom & $urandom;
      endcase
      run(1'($urandom_range(0, 1)), v, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter TRY_INVERT, default 1: when 1, a failed direct search is followed by a search of the bitwise inverse of the operand (for MVN/BIC substitution); when 0, no inverse search is done.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ValueIn  input  32  constant to encode; sampled only on the accept edge.
REQ-005 StartValid  input  1  request valid.
REQ-006 StartReady  output  1  encoder idle and able to accept a request.
REQ-007 Flush  input  1  synchronous abort; returns the encoder to IDLE.
REQ-008 DoneValid  output  1  result valid.
REQ-009 DoneReady  input  1  consumer accepts the result.
REQ-010 Encodable  output  1  an encoding was found.
REQ-011 Inverted  output  1  the encoding is of ~ValueIn.
REQ-012 Rot4  output  4  rotate field, equal to Instr[11:8].
REQ-013 Imm8  output  8  immediate field, equal to Instr[7:0].
REQ-014 EncodedOut  output  12  {Rot4, Imm8}, directly usable as Instr[11:0] of a data-processing I-type instruction.

Function
REQ-015 Encoding rule: a candidate (r, v) SHALL match when ROL(v, 2*r) has bits [31:8] all zero; Imm8 = ROL(v, 2*r)[7:0] and Rot4 = r, so ROR(zero-extended Imm8, 2*Rot4) == v.
REQ-016 The FSM SHALL have four states: IDLE, SEARCH, SEARCH_INV and DONE.
REQ-017 IDLE: StartReady = 1. On StartValid & StartReady, the encoder SHALL register ValueIn, clear the rotation counter to 0 and enter SEARCH.
REQ-018 SEARCH: each cycle tests exactly one candidate, r = counter, v = registered value.
  - On a match: latch Rot4/Imm8, set Encodable = 1, set Inverted = 0, enter DONE.
  - No match and counter < 15: counter increments.
  - No match at counter = 15, TRY_INVERT = 1: counter clears to 0, enter SEARCH_INV.
  - No match at counter = 15, TRY_INVERT = 0: set Encodable = 0, enter DONE.
REQ-019 SEARCH_INV SHALL behave as SEARCH with v = ~registered value; a match sets Inverted = 1; no match at counter = 15 sets Encodable = 0 and Inverted = 0, then enters DONE.
REQ-020 The smallest matching r SHALL be reported; the direct search always takes precedence over the inverse search.
REQ-021 Latency from the accept edge to the first cycle of DoneValid = 1 SHALL be:
  - r+1 cycles for a direct match;
  - 16+r+1 cycles for an inverse match;
  - 16 cycles (TRY_INVERT = 0) or 32 cycles (TRY_INVERT = 1) for a failure.
REQ-022 DONE: DoneValid = 1, and all result outputs SHALL hold stable until DoneValid & DoneReady, then return to IDLE on that edge. There is no bypass: a new request is accepted no earlier than the cycle after the result is consumed.
REQ-023 When Encodable = 0, Rot4, Imm8 and EncodedOut SHALL be 0.
REQ-024 DoneValid and StartReady SHALL never be 1 in the same cycle; StartReady SHALL be 0 in SEARCH, SEARCH_INV and DONE.
REQ-025 Flush = 1 SHALL force IDLE on the next edge from any state, discarding any pending result; Flush has priority over StartValid, and no request is accepted in a cycle with Flush = 1.
REQ-026 ValueIn changes after the accept edge SHALL have no effect on the operation in progress.
REQ-027 The result outputs SHALL be registered; DoneValid and StartReady SHALL be decoded from state only (no combinational path from inputs).

Reset
REQ-028 When reset is low, the encoder SHALL immediately enter IDLE and set StartReady = 1 and DoneValid = 0.
REQ-029 Reset SHALL clear Encodable, Inverted, Rot4, Imm8, EncodedOut, the counter and the operand register to 0.
REQ-030 Reset asserted mid-search SHALL abandon the operation with no result emitted; after reset releases, the first request SHALL behave as if from power-up.

Verification
REQ-031 ValueIn = 0x00000000 -> DoneValid 1 cycle after accept; Encodable = 1, Rot4 = 0, Imm8 = 0x00, Inverted = 0.
REQ-032 ValueIn = 0xFF000000 -> 5 cycles; Rot4 = 4, Imm8 = 0xFF, EncodedOut = 0x4FF. Then ValueIn = 0x000003FC -> 16 cycles; Rot4 = 15, Imm8 = 0xFF.
REQ-033 ValueIn = 0xFFFFFF00, TRY_INVERT = 1 -> 17 cycles; Encodable = 1, Inverted = 1, Rot4 = 0, Imm8 = 0xFF. With TRY_INVERT = 0 -> 16 cycles; Encodable = 0, EncodedOut = 0.
REQ-034 ValueIn = 0x00000101 -> 32 cycles; Encodable = 0, Inverted = 0. Hold DoneReady = 0 for 5 cycles -> outputs stable, StartReady = 0; pulse DoneReady -> IDLE next cycle.
REQ-035 Flush or reset (low) at cycle 8 of the 0x00000101 search -> IDLE next edge (immediately for reset); no DoneValid; an immediate follow-up request 0x000000AB -> 1 cycle, Rot4 = 0, Imm8 = 0xAB.
REQ-036 Random ValueIn scoreboard: check every reported result against ROR(Imm8, 2*Rot4), inverted when Inverted = 1, and against a reference minimal-r search.
